// File: rtl/mdr_pkg.sv
// Shared types and constants for the Memory Data Register and its memory handshake.
// Optional timeout support is enabled by defining MDR_TIMEOUT_EN.
package mdr_pkg;

  localparam int MDR_ADDR_W = 9;
  localparam int MDR_DATA_W = 32;

  // Bus multiplexer select code that routes MDR onto the internal bus.
  localparam logic [4:0] MDR_BUS_SEL = 5'b10101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdrState_e;

endpackage

// File: rtl/mdr_wait_timer.sv
// Clear/enable wait-state counter; 'expire' flags the wait cycle that reaches LIMIT.
// Used by mdr_mem_if only when MDR_TIMEOUT_EN is defined.
module mdr_wait_timer
  import mdr_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CountW = $clog2(LIMIT + 1);

  logic [CountW-1:0] waitCount;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      waitCount <= '0;
    end else if (clear) begin
      waitCount <= '0;
    end else if (enable) begin
      waitCount <= waitCount + 1'b1;
    end
  end

  // Counter holds the number of completed idle waits, so LIMIT-1 means this is the last one.
  assign expire = enable && (waitCount == CountW'(LIMIT - 1));

endmodule

// File: rtl/mdr_mem_if.sv
// Memory Data Register with single-word read/write handshake sequencer toward data memory.
// Define MDR_TIMEOUT_EN to bound wait states by TIMEOUT_CYCLES and report aborts on err.
module mdr_mem_if
  import mdr_pkg::*;
#(
  parameter int ADDR_W         = MDR_ADDR_W,
  parameter int DATA_W         = MDR_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mdrState_e         state;
  mdrState_e         stateNext;
  logic [DATA_W-1:0] mdrNext;
  logic [ADDR_W-1:0] addrNext;
  logic              rdNext;
  logic              wrNext;
  logic              busyNext;
  logic              doneNext;
  logic              timeout;

`ifdef MDR_TIMEOUT_EN
  logic waitClear;
  logic waitEnable;
  logic errNext;

  assign waitClear  = (state == IDLE);
  assign waitEnable = (state != IDLE) && !mem_ack;

  mdr_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uWaitTimer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (waitClear),
    .enable (waitEnable),
    .expire (timeout)
  );

  // Sticky until the next accepted transaction; a same-cycle ack never reaches here.
  always_comb begin
    errNext = err;
    if ((state == IDLE) && (rd_start || wr_start)) begin
      errNext = 1'b0;
    end else if (timeout) begin
      errNext = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= errNext;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    mdrNext   = mdr_out;
    addrNext  = mem_addr;
    rdNext    = 1'b0;
    wrNext    = 1'b0;
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_start) begin
          stateNext = RD_WAIT;
          addrNext  = addr;
          rdNext    = 1'b1;
          busyNext  = 1'b1;
        end else if (wr_start) begin
          stateNext = WR_WAIT;
          addrNext  = addr;
          wrNext    = 1'b1;
          busyNext  = 1'b1;
        end else if (mdr_in) begin
          mdrNext = bus_in;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          mdrNext   = mem_rdata;
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else if (timeout) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          rdNext   = 1'b1;
          busyNext = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack || timeout) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else begin
          wrNext   = 1'b1;
          busyNext = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Every handshake output is a register so memory never sees combinational glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mdr_out  <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mdr_out  <= mdrNext;
      mem_addr <= addrNext;
      mem_rd   <= rdNext;
      mem_wr   <= wrNext;
      busy     <= busyNext;
      done     <= doneNext;
    end
  end

  assign mem_wdata = mdr_out;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Scoreboard bench for mdr_mem_if: the driver acts as memory and pushes expected completions,
// a negedge monitor pops them on every done pulse. Handles builds with or without MDR_TIMEOUT_EN.
module tb_mdr_mem_if;

  localparam int TIMEOUT = 4;

`ifdef MDR_TIMEOUT_EN
  localparam bit ToEnabled = 1'b1;
`else
  localparam bit ToEnabled = 1'b0;
`endif

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] mdr;
    logic        err;
  } expect_t;

  logic        clock;
  logic        reset_n;
  logic [31:0] bus_in;
  logic        mdr_in;
  logic        rd_start;
  logic        wr_start;
  logic [8:0]  addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] mdr_out;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  int          assertCount = 0;
  int          failCount   = 0;
  expect_t     expQ[$];
  logic [31:0] modelMdr = '0;
  logic        modelErr = 1'b0;

  mdr_mem_if #(
    .ADDR_W(9),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus_in   (bus_in),
    .mdr_in   (mdr_in),
    .rd_start (rd_start),
    .wr_start (wr_start),
    .addr     (addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mdr_out  (mdr_out),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: each done pulse must match the oldest outstanding transaction.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        checkOutput("rdWrExclusive", {31'b0, mem_rd & mem_wr}, 32'h0);
        if (done) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", {31'b0, done}, 32'h0);
          end else begin
            e = expQ.pop_front();
            checkOutput("doneMdr", mdr_out, e.mdr);
            checkOutput("doneErr", {31'b0, err}, {31'b0, e.err});
            checkOutput("doneAddr", {23'b0, mem_addr}, {23'b0, e.addr});
            checkOutput("doneBusy", {31'b0, busy}, 32'h0);
          end
        end
      end
    end
  end

  task automatic doIdle();
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clock);
    checkOutput("idleMdr", mdr_out, modelMdr);
    checkOutput("idleErr", {31'b0, err}, {31'b0, modelErr});
    checkOutput("idleBusy", {31'b0, busy}, 32'h0);
    @(posedge clock); #1;
    mem_ack = 1'b0;
  endtask

  task automatic doBusLoad(input logic [31:0] val);
    mdr_in  = 1'b1;
    bus_in  = val;
    mem_ack = 1'($urandom);
    @(posedge clock); #1;
    mdr_in   = 1'b0;
    mem_ack  = 1'b0;
    modelMdr = val;
    @(negedge clock);
    checkOutput("busLoadMdr", mdr_out, modelMdr);
    checkOutput("busLoadBusy", {31'b0, busy}, 32'h0);
    checkOutput("busLoadDone", {31'b0, done}, 32'h0);
    checkOutput("busLoadErr", {31'b0, err}, {31'b0, modelErr});
    @(posedge clock); #1;
  endtask

  // waits = idle wait cycles before the ack cycle; too many aborts when timeout is built.
  task automatic doRead(input logic [8:0] a, input logic [31:0] d, input int waits,
                        input logic alsoWr, input logic alsoBus, input logic [31:0] busVal);
    bit abort;
    int cycles;
    abort    = ToEnabled && (waits >= TIMEOUT);
    cycles   = abort ? TIMEOUT : waits + 1;
    rd_start = 1'b1;
    wr_start = alsoWr;
    mdr_in   = alsoBus;
    bus_in   = busVal;
    addr     = a;
    if (abort) begin
      expQ.push_back('{addr: a, mdr: modelMdr, err: 1'b1});
      modelErr = 1'b1;
    end else begin
      expQ.push_back('{addr: a, mdr: d, err: 1'b0});
      modelMdr = d;
      modelErr = 1'b0;
    end
    @(posedge clock); #1;
    addr = 9'($urandom);
    for (int c = 0; c < cycles; c++) begin
      mem_ack   = !abort && (c == waits);
      mem_rdata = mem_ack ? d : $urandom;
      rd_start  = 1'($urandom);
      wr_start  = 1'($urandom);
      mdr_in    = 1'($urandom);
      bus_in    = $urandom;
      @(negedge clock);
      checkOutput("rdReq", {31'b0, mem_rd}, 32'h1);
      checkOutput("rdNoWr", {31'b0, mem_wr}, 32'h0);
      checkOutput("rdBusy", {31'b0, busy}, 32'h1);
      checkOutput("rdAddr", {23'b0, mem_addr}, {23'b0, a});
      @(posedge clock); #1;
    end
    mem_ack  = 1'b0;
    rd_start = 1'b0;
    wr_start = 1'b0;
    mdr_in   = 1'b0;
  endtask

  task automatic doWrite(input logic [8:0] a, input int waits, input logic [31:0] busVal);
    bit abort;
    int cycles;
    logic [31:0] held;
    abort    = ToEnabled && (waits >= TIMEOUT);
    cycles   = abort ? TIMEOUT : waits + 1;
    held     = modelMdr;
    wr_start = 1'b1;
    rd_start = 1'b0;
    mdr_in   = 1'b0;
    addr     = a;
    expQ.push_back('{addr: a, mdr: held, err: abort});
    modelErr = abort;
    @(posedge clock); #1;
    wr_start = 1'b0;
    addr     = 9'($urandom);
    for (int c = 0; c < cycles; c++) begin
      mem_ack   = !abort && (c == waits);
      mem_rdata = $urandom;
      rd_start  = 1'($urandom);
      mdr_in    = 1'b1;
      bus_in    = busVal;
      @(negedge clock);
      checkOutput("wrReq", {31'b0, mem_wr}, 32'h1);
      checkOutput("wrNoRd", {31'b0, mem_rd}, 32'h0);
      checkOutput("wrBusy", {31'b0, busy}, 32'h1);
      checkOutput("wrData", mem_wdata, held);
      checkOutput("wrAddr", {23'b0, mem_addr}, {23'b0, a});
      @(posedge clock); #1;
    end
    mem_ack  = 1'b0;
    rd_start = 1'b0;
    mdr_in   = 1'b0;
  endtask

  task automatic applyStimulus(input int ops);
    for (int i = 0; i < ops; i++) begin
      case ($urandom_range(0, 3))
        0: doBusLoad($urandom);
        1: doRead(9'($urandom), $urandom, $urandom_range(0, 6),
                  1'($urandom), 1'($urandom), $urandom);
        2: doWrite(9'($urandom), $urandom_range(0, 6), $urandom);
        default: doIdle();
      endcase
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    bus_in    = '0;
    mdr_in    = 1'b0;
    rd_start  = 1'b0;
    wr_start  = 1'b0;
    addr      = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rstMdr", mdr_out, 32'h0);
    checkOutput("rstAddr", {23'b0, mem_addr}, 32'h0);
    checkOutput("rstWdata", mem_wdata, 32'h0);
    checkOutput("rstRd", {31'b0, mem_rd}, 32'h0);
    checkOutput("rstWr", {31'b0, mem_wr}, 32'h0);
    checkOutput("rstBusy", {31'b0, busy}, 32'h0);
    checkOutput("rstDone", {31'b0, done}, 32'h0);
    checkOutput("rstErr", {31'b0, err}, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    doBusLoad(32'hDEADBEEF);
    doRead(9'h05E, 32'h12345678, 2, 1'b0, 1'b0, 32'h0);
    doIdle();

    doBusLoad(32'hCAFEF00D);
    doWrite(9'h010, 3, 32'h0);
    doIdle();

    // All three requests at once: read wins, then a write back-to-back in the done cycle.
    doRead(9'h1C3, 32'hA5A5_0F0F, 1, 1'b1, 1'b1, 32'hBAD0BAD0);
    doWrite(9'h033, 1, 32'h0BADF00D);
    doIdle();

    // Asynchronous reset in the middle of a read.
    rd_start = 1'b1;
    addr     = 9'h1AA;
    @(posedge clock); #1;
    rd_start = 1'b0;
    @(negedge clock);
    checkOutput("preRstRd", {31'b0, mem_rd}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncRstRd", {31'b0, mem_rd}, 32'h0);
    checkOutput("asyncRstBusy", {31'b0, busy}, 32'h0);
    checkOutput("asyncRstMdr", mdr_out, 32'h0);
    checkOutput("asyncRstAddr", {23'b0, mem_addr}, 32'h0);
    @(posedge clock); #1;
    reset_n   = 1'b1;
    modelMdr  = '0;
    modelErr  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    doIdle();
    doIdle();

`ifdef MDR_TIMEOUT_EN
    doBusLoad(32'h11111111);
    doRead(9'h0F0, 32'h22222222, TIMEOUT + 1, 1'b0, 1'b0, 32'h0);
    doIdle();
    doWrite(9'h0F2, TIMEOUT + 2, 32'h0);
    doIdle();
    doRead(9'h0F1, 32'h33333333, TIMEOUT - 1, 1'b0, 1'b0, 32'h0);
    doIdle();
`else
    doRead(9'h0F0, 32'h22222222, 3 * TIMEOUT, 1'b0, 1'b0, 32'h0);
    doIdle();
`endif

    applyStimulus(60);

    repeat (3) doIdle();
    checkOutput("queueDrained", expQ.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
- Memory Data Register plus its memory-side handshake controller.
- Its registered output drives the bus multiplexer's MDR source (select 5'b10101).
- Loads either from the internal bus (BusMuxOut) or from memory on a read.
- Sequences single-word read/write transactions to data memory using the address held by MAR, and reports completion to the control unit.

Parameters:
- ADDR_W, 9, memory address width (word-addressed, from MAR).
- DATA_W, 32, data width of MDR, bus and memory.
- TIMEOUT_CYCLES, 16, wait-state limit before abort (used only with MDR_TIMEOUT_EN).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- bus_in  in  DATA_W  BusMuxOut, the internal bus value.
- mdr_in  in  1  load MDR from bus_in at the next edge (IDLE only).
- rd_start  in  1  start a memory read into MDR.
- wr_start  in  1  start a memory write of MDR.
- addr  in  ADDR_W  MAR contents, sampled on start.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1.
- mem_ack  in  1  memory completes the current transaction.
- mdr_out  out  DATA_W  MDR contents; feeds the bus mux MDR input.
- mem_addr  out  ADDR_W  registered transaction address.
- mem_wdata  out  DATA_W  equals mdr_out.
- mem_rd  out  1  read request, held until ack.
- mem_wr  out  1  write request, held until ack.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag (tied 0 without MDR_TIMEOUT_EN).

Behaviour:
- Reset (async, active-low): state=IDLE; mdr_out=0, mem_addr=0, mem_rd=0, mem_wr=0, busy=0, done=0, err=0.
- States: IDLE, RD_WAIT, WR_WAIT. All outputs are registered.
- IDLE, arbitration by priority rd_start > wr_start > mdr_in:
  - rd_start: latch addr into mem_addr; go to RD_WAIT; mem_rd=1 and busy=1 from the next cycle.
  - wr_start: as for rd_start, but go to WR_WAIT with mem_wr=1.
  - mdr_in: mdr_out <= bus_in at the next edge. This is a 1-cycle load and does not assert busy or done.
  - A losing request in the same cycle is dropped, not queued.
- RD_WAIT:
  - When mem_ack=1 at an edge: mdr_out <= mem_rdata; mem_rd=0; busy=0; done=1 for exactly the following cycle; return to IDLE.
  - Minimum latency rd_start to done is 2 cycles (ack in the first wait cycle).
- WR_WAIT:
  - mem_wdata=mdr_out, held stable throughout.
  - On mem_ack: mem_wr=0, busy=0, done pulse, return to IDLE. MDR is unchanged.
- In wait states, mdr_in, rd_start and wr_start are ignored. MDR and mem_addr are frozen except by read completion.
- mem_ack in IDLE is ignored.
- A new start may be accepted in the same cycle that done is high (back-to-back operation).
- mem_rd and mem_wr are never high together.
- reset_n asserted mid-transaction aborts immediately to the reset values. The memory sees the request drop.

Optional Feature:
- Macro: MDR_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to RD_WAIT/WR_WAIT and increments each wait cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: abort to IDLE, drop mem_rd/mem_wr, pulse done, set err=1.
  - On a read abort, MDR keeps its old value.
  - err clears when the next rd_start or wr_start is accepted.
  - An ack arriving in the same cycle as the limit wins: normal completion, err not set.
- When undefined: no counter is built, wait states are unbounded, and err is constant 0.

Decomposition:
- Package mdr_pkg:
  - state enum (IDLE, RD_WAIT, WR_WAIT);
  - default ADDR_W/DATA_W constants;
  - MDR_BUS_SEL=5'b10101, shared with bus-select encoding.
- One natural sub-module: mdr_wait_timer, a clear/enable counter with a terminal-count output. It is instantiated only under MDR_TIMEOUT_EN.

Test Plan:
- Reset and bus load: hold reset_n=0, check all outputs 0. Release, pulse mdr_in with bus_in=32'hDEADBEEF → mdr_out=32'hDEADBEEF next cycle, busy=0, done=0.
- Read with wait states: rd_start, addr=9'h05E; ack after 3 wait cycles with mem_rdata=32'h12345678 → mem_rd high for 3 cycles, mem_addr=9'h05E, mdr_out=32'h12345678, single done pulse.
- Write: mdr_out=32'hCAFEF00D, wr_start, addr=9'h010; in WR_WAIT drive mdr_in with bus_in=32'h0 → mem_wdata stays 32'hCAFEF00D until ack, and MDR is unchanged afterwards.
- Simultaneous starts: rd_start, wr_start and mdr_in all high in IDLE → read only, mem_wr never asserted, bus load dropped. Then back-to-back wr_start in the done cycle → accepted.
- Reset mid-read: assert reset_n in RD_WAIT → mem_rd, busy and mdr_out drop to 0 asynchronously. A later ack causes no done.
- MDR_TIMEOUT_EN with TIMEOUT_CYCLES=4: read with no ack → abort after 4 wait cycles, done=1, err=1, MDR old value kept. Next rd_start clears err. Ack on cycle 4 → normal completion, err=0.
